// File: rtl/rr_mux_arbiter_4ch.sv
// Round-robin arbiter for a shared 4:1 data mux: grants one requester at a time,
// caps each grant at MAX_HOLD back-to-back transfers, and registers the selected word.
module rr_mux_arbiter_4ch #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [3:0]            req_in,
  input  logic [4*DATA_W-1:0]   d_in,
  output logic [3:0]            grant_out,
  output logic [1:0]            sel_out,
  output logic [DATA_W-1:0]     y_out,
  output logic                  valid_out,
  output logic                  busy_out
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t              r_state;
  logic [3:0]          r_grant;
  logic [1:0]          r_sel;
  logic [1:0]          r_ptr;
  logic [HW-1:0]       r_hold;
  logic [DATA_W-1:0]   r_y;
  logic                r_valid;
  logic                r_busy;

  logic [2:0]          w_pick_idle;
  logic [2:0]          w_pick_rot;
  logic [3:0]          w_others;
  logic [1:0]          w_after_owner;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_after_owner = r_sel + 2'd1;
  assign w_others      = req_in & ~r_grant;
  assign w_pick_idle   = pick(req_in, r_ptr);
  assign w_pick_rot    = pick(w_others, w_after_owner);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_hold  <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_idle[2]) begin
            r_state <= ST_GRANT;
            r_grant <= 4'b0001 << w_pick_idle[1:0];
            r_sel   <= w_pick_idle[1:0];
            r_busy  <= 1'b1;
            r_hold  <= '0;
          end
        end
        ST_GRANT: begin
          if (req_in[r_sel]) begin
            r_valid <= 1'b1;
            r_y     <= d_in[r_sel*DATA_W +: DATA_W];
            if (r_hold == HOLD_LAST) begin
              // Burst limit reached: hand over without a bubble if anyone else waits.
              r_hold <= '0;
              if (w_pick_rot[2]) begin
                r_grant <= 4'b0001 << w_pick_rot[1:0];
                r_sel   <= w_pick_rot[1:0];
                r_ptr   <= w_after_owner;
              end
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end else begin
            r_ptr  <= w_after_owner;
            r_hold <= '0;
            if (w_pick_rot[2]) begin
              r_grant <= 4'b0001 << w_pick_rot[1:0];
              r_sel   <= w_pick_rot[1:0];
            end else begin
              r_state <= ST_IDLE;
              r_grant <= 4'b0000;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_out = r_grant;
  assign sel_out   = r_sel;
  assign y_out     = r_y;
  assign valid_out = r_valid;
  assign busy_out  = r_busy;

endmodule

// File: tb/tb_rr_mux_arbiter_4ch.sv
// Self-checking bench for rr_mux_arbiter_4ch: directed scenarios plus randomized
// traffic, all compared against a burst-level round-robin reference model.
module tb_rr_mux_arbiter_4ch;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [3:0]  req_in;
  logic [31:0] d_in;
  logic [3:0]  grant_out;
  logic [1:0]  sel_out;
  logic [7:0]  y_out;
  logic        valid_out;
  logic        busy_out;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cycle = 0;

  // Reference model: current owner (-1 when idle), search pointer, transfers in this burst.
  int         m_owner;
  int         m_ptr;
  int         m_cnt;
  int         m_sel;
  logic [7:0] m_y;
  logic       m_valid;

  rr_mux_arbiter_4ch #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .req_in    (req_in),
    .d_in      (d_in),
    .grant_out (grant_out),
    .sel_out   (sel_out),
    .y_out     (y_out),
    .valid_out (valid_out),
    .busy_out  (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, n_cycle, obs, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] req, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (req[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    int g;
    if (!rst_n_in) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_y = 8'h00; m_valid = 1'b0;
      return;
    end
    m_valid = 1'b0;
    g = m_owner;
    if (g < 0) begin
      w = winner(req_in, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_cnt = 0;
      end
    end else if (req_in[g]) begin
      m_valid = 1'b1;
      m_y     = d_in[g*8 +: 8];
      m_cnt++;
      if (m_cnt == MAX_HOLD) begin
        m_cnt = 0;
        w = winner(req_in, (g + 1) % 4, g);
        if (w >= 0) begin
          m_ptr = (g + 1) % 4; m_owner = w; m_sel = w;
        end
      end
    end else begin
      m_ptr = (g + 1) % 4;
      m_cnt = 0;
      w = winner(req_in, (g + 1) % 4, g);
      if (w >= 0) begin
        m_owner = w; m_sel = w;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic step();
    logic [3:0] exp_grant;
    @(posedge clk_in);
    model_update();
    n_cycle++;
    #1;
    exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("grant", 32'(grant_out), 32'(exp_grant));
    check("sel",   32'(sel_out),   32'(m_sel));
    check("y",     32'(y_out),     32'(m_y));
    check("valid", 32'(valid_out), 32'(m_valid));
    check("busy",  32'(busy_out),  32'(m_owner >= 0));
    $display("[TB] cyc %0d rst_n=%0b req=%04b grant=%04b sel=%0d valid=%0b y=%02h",
             n_cycle, rst_n_in, req_in, grant_out, sel_out, valid_out, y_out);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
  endtask

  initial begin
    rst_n_in = 1'b0;
    req_in   = 4'h0;
    d_in     = 32'h0;

    // 1: reset held with all requests active
    req_in = 4'hF;
    step(); step();
    check("rst_grant", 32'(grant_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_y",     32'(y_out),     32'h0);
    check("rst_busy",  32'(busy_out),  32'h0);

    // 2: single requester, continuous transfers across hold rollover
    rst_n_in = 1'b1;
    req_in = 4'b0100;
    d_in   = 32'h00A5_0000;
    step();
    check("s2_grant", 32'(grant_out), 32'h4);
    check("s2_sel",   32'(sel_out),   32'h2);
    for (int i = 0; i < 10; i++) begin
      step();
      check("s2_valid", 32'(valid_out), 32'h1);
      check("s2_y",     32'(y_out),     32'hA5);
    end

    // 3: all request, bursts of MAX_HOLD rotate 0,1,2,3,0
    do_reset();
    req_in = 4'hF;
    d_in   = 32'h1312_1110;
    step();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] exp_y;
      exp_y = 8'h10 + 8'((i / MAX_HOLD) % 4);
      step();
      check("s3_valid", 32'(valid_out), 32'h1);
      check("s3_y",     32'(y_out),     32'(exp_y));
    end

    // 4: owner ch1 drops after 2 transfers, ch3 takes over; ch0 later must wait
    do_reset();
    req_in = 4'b0010;
    d_in   = 32'h4433_2211;
    step(); step(); step();
    req_in = 4'b1000;
    step();
    check("s4_drop_valid", 32'(valid_out), 32'h0);
    check("s4_regrant",    32'(grant_out), 32'h8);
    req_in = 4'b1001;
    step();
    check("s4_hold_ch3",   32'(grant_out), 32'h8);

    // 5: reset mid-burst, then ch0 wins from ptr 0
    do_reset();
    req_in = 4'b0100;
    step(); step(); step();
    rst_n_in = 1'b0;
    step();
    check("s5_grant", 32'(grant_out), 32'h0);
    check("s5_valid", 32'(valid_out), 32'h0);
    check("s5_y",     32'(y_out),     32'h0);
    rst_n_in = 1'b1;
    req_in = 4'b0101;
    step();
    check("s5_ch0",   32'(grant_out), 32'h1);

    // 6: ch3 burst ends, wrap to ch0, then go idle
    do_reset();
    req_in = 4'b1000;
    step();
    req_in = 4'b1001;
    for (int i = 0; i < MAX_HOLD; i++) step();
    check("s6_wrap", 32'(grant_out), 32'h1);
    req_in = 4'b0000;
    step();
    check("s6_idle_grant", 32'(grant_out), 32'h0);
    check("s6_idle_busy",  32'(busy_out),  32'h0);
    step();

    // Randomized traffic, with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n_in = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) req_in = 4'($urandom);
      else if ($urandom_range(0, 7) == 0) req_in = 4'h0;
      d_in = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
